// File: rtl/ifu_pkg.sv
// ifu_pkg: shared IFU widths, reset PC, fetch FSM states and in-flight tag type
package ifu_pkg;
    localparam int INST_ADDR_WIDTH = 32;
    localparam int INST_DATA_WIDTH = 32;
    localparam logic [INST_ADDR_WIDTH-1:0] PCResetAddr = 32'h8000_0000;
    typedef enum logic [1:0] {RESET, FETCH, ARWAIT} ifu_fc_state_e;
    typedef struct packed {
        logic [INST_ADDR_WIDTH-1:0] addr;
        logic                       stale;
    } ifu_fc_tag_t;
endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// ifu_fetch_ctrl_if: AXI4 AR/R read channels plus the IF pipe instruction handshake
interface ifu_fetch_ctrl_if
    import ifu_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_WIDTH,
    parameter int DATA_W = INST_DATA_WIDTH
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_valid;
    logic              inst_err;
    logic              inst_ready;
    modport master (
        output arvalid, araddr, rready, inst, inst_addr, inst_valid, inst_err,
        input  arready, rvalid, rdata, rresp, inst_ready
    );
    modport slave (
        input  arvalid, araddr, rready, inst, inst_addr, inst_valid, inst_err,
        output arready, rvalid, rdata, rresp, inst_ready
    );
endinterface

// File: rtl/ifu_fetch_tag_fifo.sv
// ifu_fetch_tag_fifo: in-order tag store for in-flight reads; mark_all sets every stale bit.
// DEPTH must be a power of two so the pointers wrap on their own.
module ifu_fetch_tag_fifo
    import ifu_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type tag_t = ifu_fc_tag_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   mark_all,
    input  tag_t                   push_tag,
    output tag_t                   head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    tag_t          mem_q [DEPTH];
    tag_t          mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        mem_d = mem_q;
        if (mark_all) for (int i = 0; i < DEPTH; i++) mem_d[i].stale = 1'b1;
        if (push) mem_d[wr_q] = push_tag;
        wr_d  = wr_q + PW'(push);
        rd_d  = rd_q + PW'(pop);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    assign head  = mem_q[rd_q];
    assign count = cnt_q;
endmodule

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: AXI4 single-beat instruction fetch sequencer with up to MAX_OUTS reads in flight.
// Redirects mark in-flight tags stale instead of stalling; stale beats are drained and dropped.
module ifu_fetch_ctrl
    import ifu_pkg::*;
#(
    parameter int ADDR_W   = INST_ADDR_WIDTH,
    parameter int DATA_W   = INST_DATA_WIDTH,
    parameter int MAX_OUTS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      jump_flag_i,
    input  logic [ADDR_W-1:0]         jump_addr_i,
    input  logic                      hold_pc_i,
    ifu_fetch_ctrl_if.master          bus,
    output logic [ADDR_W-1:0]         pc_o,
    output logic [$clog2(MAX_OUTS):0] outs_cnt_o
);
    localparam int CW = $clog2(MAX_OUTS) + 1;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              stale;
    } tag_t;
    ifu_fc_state_e     state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, araddr_q, araddr_d, next_pc;
    logic              arvalid_q, arvalid_d, redir_pend_q, redir_pend_d;
    logic              ar_hs, r_hs, rready, empty, issue;
    logic [CW-1:0]     cnt, cnt_next;
    logic [DATA_W-1:0] rdata;
    tag_t              head, push_tag;
    ifu_fetch_tag_fifo #(.DEPTH(MAX_OUTS), .tag_t(tag_t)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (ar_hs),
        .pop      (r_hs),
        .mark_all (jump_flag_i),
        .push_tag (push_tag),
        .head     (head),
        .count    (cnt)
    );
    assign empty    = cnt == '0;
    assign ar_hs    = arvalid_q & bus.arready;
    assign rready   = !empty & (head.stale | (bus.inst_ready & !jump_flag_i));
    assign r_hs     = bus.rvalid & rready;
    assign cnt_next = cnt + CW'(ar_hs) - CW'(r_hs);
    assign push_tag = '{addr: araddr_q, stale: redir_pend_q | jump_flag_i};
    // Using the post-handshake count keeps back-to-back issue from ever overfilling the tag FIFO.
    assign issue    = !hold_pc_i && cnt_next < CW'(MAX_OUTS) && (state_q != ARWAIT || ar_hs);
    assign next_pc  = jump_flag_i ? jump_addr_i
                    : (ar_hs && !redir_pend_q) ? araddr_q + ADDR_W'(4) : pc_q;
    always_comb begin
        pc_d         = next_pc;
        arvalid_d    = issue | (arvalid_q & !bus.arready);
        araddr_d     = issue ? next_pc : araddr_q;
        redir_pend_d = arvalid_q & !bus.arready & (redir_pend_q | jump_flag_i);
        state_d      = arvalid_d ? ARWAIT : FETCH;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RESET;
            pc_q         <= ADDR_W'(PCResetAddr);
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            redir_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            redir_pend_q <= redir_pend_d;
        end
    end
    assign rdata          = bus.rdata;
    assign bus.arvalid    = arvalid_q;
    assign bus.araddr     = araddr_q;
    assign bus.rready     = rready;
    assign bus.inst       = rdata;
    assign bus.inst_addr  = head.addr;
    assign bus.inst_valid = bus.rvalid & !empty & !head.stale & !jump_flag_i;
    assign bus.inst_err   = bus.rresp != 2'b00;
    assign pc_o           = pc_q;
    assign outs_cnt_o     = cnt;
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: directed scenarios for the fetch sequencer with hand-computed expectations
module tb_ifu_fetch_ctrl;
    import ifu_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump = 1'b0;
    logic        hold = 1'b0;
    logic [31:0] jaddr = '0;
    logic [31:0] pc;
    logic [2:0]  cnt;
    int          checks = 0;
    int          failures = 0;
    int          n_ar;
    ifu_fetch_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    ifu_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .jump_flag_i (jump),
        .jump_addr_i (jaddr),
        .hold_pc_i   (hold),
        .bus         (bus),
        .pc_o        (pc),
        .outs_cnt_o  (cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset;
        rst = 1'b1;
        jump = 1'b0;
        hold = 1'b0;
        jaddr = '0;
        bus.arready = 1'b0;
        bus.rvalid = 1'b0;
        bus.rdata = '0;
        bus.rresp = 2'b00;
        bus.inst_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask
    // An R beat with nothing in flight must never be accepted.
    always @(negedge clk) if (!rst && bus.rvalid && cnt == 3'd0) chk("rvalid_empty_rready", bus.rready, 0);
    initial begin
        do_reset;
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_araddr", bus.araddr, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_ivalid", bus.inst_valid, 0);
        chk("rst_rready", bus.rready, 0);
        bus.rvalid = 1'b1;
        #1;
        chk("empty_rready", bus.rready, 0);
        chk("empty_ivalid", bus.inst_valid, 0);
        bus.rvalid = 1'b0;
        rst = 1'b0;
        bus.arready = 1'b1;
        tick;
        chk("first_arvalid", bus.arvalid, 1);
        chk("first_araddr", bus.araddr, 32'h8000_0000);
        for (int k = 0; k < 4; k++) begin
            tick;
            bus.rvalid = 1'b1;
            bus.rdata = 32'hD000_0000 + k;
            #1;
            chk("stream_araddr", bus.araddr, 32'h8000_0004 + 4 * k);
            chk("stream_iaddr", bus.inst_addr, 32'h8000_0000 + 4 * k);
            chk("stream_ivalid", bus.inst_valid, 1);
            chk("stream_inst", bus.inst, 32'hD000_0000 + k);
        end
        tick;
        bus.arready = 1'b0;
        bus.inst_ready = 1'b0;
        bus.rdata = 32'hCAFE_0001;
        bus.rresp = 2'b10;
        #1;
        chk("irdy0_rready", bus.rready, 0);
        chk("irdy0_ivalid", bus.inst_valid, 1);
        chk("irdy0_iaddr", bus.inst_addr, 32'h8000_0010);
        chk("err_flag", bus.inst_err, 1);
        chk("irdy0_cnt", cnt, 1);
        tick;
        chk("irdy0_hold_iaddr", bus.inst_addr, 32'h8000_0010);
        chk("irdy0_hold_inst", bus.inst, 32'hCAFE_0001);
        chk("irdy0_hold_cnt", cnt, 1);
        chk("arwait_arvalid", bus.arvalid, 1);
        chk("arwait_araddr", bus.araddr, 32'h8000_0014);
        rst = 1'b1;
        #1;
        chk("midrst_cnt", cnt, 0);
        chk("midrst_arvalid", bus.arvalid, 0);
        chk("midrst_pc", pc, 32'h8000_0000);
        do_reset;
        rst = 1'b0;
        bus.arready = 1'b1;
        n_ar = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (bus.arvalid && bus.arready) n_ar++;
        end
        chk("full_ar_count", n_ar, 4);
        chk("full_cnt", cnt, 4);
        chk("full_arvalid", bus.arvalid, 0);
        chk("full_pc", pc, 32'h8000_0010);
        bus.rvalid = 1'b1;
        bus.rdata = 32'h0000_1111;
        #1;
        chk("full_ivalid", bus.inst_valid, 1);
        chk("full_iaddr", bus.inst_addr, 32'h8000_0000);
        tick;
        chk("fifth_arvalid", bus.arvalid, 1);
        chk("fifth_araddr", bus.araddr, 32'h8000_0010);
        chk("fifth_cnt", cnt, 3);
        chk("fifth_iaddr", bus.inst_addr, 32'h8000_0004);
        tick;
        chk("pushpop_cnt", cnt, 3);
        chk("pushpop_araddr", bus.araddr, 32'h8000_0014);
        do_reset;
        rst = 1'b0;
        bus.arready = 1'b1;
        repeat (3) tick;
        chk("jif_pre_cnt", cnt, 2);
        chk("jif_pre_araddr", bus.araddr, 32'h8000_0008);
        jump = 1'b1;
        jaddr = 32'h0000_0100;
        tick;
        jump = 1'b0;
        bus.arready = 1'b0;
        bus.rvalid = 1'b1;
        #1;
        chk("jif_araddr", bus.araddr, 32'h100);
        chk("jif_pc", pc, 32'h100);
        chk("jif_cnt", cnt, 3);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick;
            chk("jif_stale_rready", bus.rready, 1);
            chk("jif_stale_ivalid", bus.inst_valid, 0);
        end
        tick;
        bus.rvalid = 1'b0;
        bus.arready = 1'b1;
        #1;
        chk("jif_drained_cnt", cnt, 0);
        tick;
        bus.rvalid = 1'b1;
        bus.rdata = 32'h0000_0BAD;
        #1;
        chk("jif_new_ivalid", bus.inst_valid, 1);
        chk("jif_new_iaddr", bus.inst_addr, 32'h100);
        chk("jif_new_cnt", cnt, 1);
        do_reset;
        rst = 1'b0;
        jump = 1'b1;
        jaddr = 32'h0000_0020;
        tick;
        jump = 1'b0;
        #1;
        chk("jaw_arvalid", bus.arvalid, 1);
        chk("jaw_araddr0", bus.araddr, 32'h20);
        jump = 1'b1;
        jaddr = 32'h0000_0200;
        tick;
        jump = 1'b0;
        #1;
        chk("jaw_araddr1", bus.araddr, 32'h20);
        chk("jaw_pc", pc, 32'h200);
        tick;
        chk("jaw_araddr2", bus.araddr, 32'h20);
        bus.arready = 1'b1;
        tick;
        bus.arready = 1'b0;
        bus.rvalid = 1'b1;
        #1;
        chk("jaw_next_araddr", bus.araddr, 32'h200);
        chk("jaw_next_arvalid", bus.arvalid, 1);
        chk("jaw_cnt", cnt, 1);
        chk("jaw_stale_rready", bus.rready, 1);
        chk("jaw_stale_ivalid", bus.inst_valid, 0);
        tick;
        bus.rvalid = 1'b0;
        bus.arready = 1'b1;
        hold = 1'b1;
        #1;
        chk("jaw_drained_cnt", cnt, 0);
        tick;
        bus.arready = 1'b0;
        bus.rvalid = 1'b1;
        bus.rdata = 32'h0000_2222;
        #1;
        chk("jaw_new_ivalid", bus.inst_valid, 1);
        chk("jaw_new_iaddr", bus.inst_addr, 32'h200);
        chk("hold_arvalid", bus.arvalid, 0);
        jump = 1'b1;
        jaddr = 32'h0000_0300;
        #1;
        chk("sim_jump_ivalid", bus.inst_valid, 0);
        chk("sim_jump_rready", bus.rready, 0);
        tick;
        jump = 1'b0;
        #1;
        chk("jump_hold_pc", pc, 32'h300);
        chk("jump_hold_arvalid", bus.arvalid, 0);
        chk("sim_drop_rready", bus.rready, 1);
        chk("sim_drop_ivalid", bus.inst_valid, 0);
        chk("sim_drop_cnt", cnt, 1);
        tick;
        bus.rvalid = 1'b0;
        #1;
        chk("sim_final_cnt", cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
